// File: rtl/ita_tcdm_lane_sequencer.sv
// ita_tcdm_lane_sequencer: issues one wide TCDM transaction as MP narrow lane requests and reassembles the read response.
// Optional feature macro ITA_TCDM_LANE_SKIP_EN: write lanes with all-zero byte enables are never requested.
module ita_tcdm_lane_sequencer #(
    parameter int AccDataWidth = 1024,
    parameter int MemDataWidth = 64,
    parameter int MP           = AccDataWidth / MemDataWidth
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wide_req_i,
    output logic                         wide_gnt_o,
    input  logic [31:0]                  wide_add_i,
    input  logic                         wide_wen_i,
    input  logic [AccDataWidth/8-1:0]    wide_be_i,
    input  logic [AccDataWidth-1:0]      wide_data_i,
    output logic                         wide_r_valid_o,
    output logic [AccDataWidth-1:0]      wide_r_data_o,
    output logic [MP-1:0]                tcdm_req_o,
    input  logic [MP-1:0]                tcdm_gnt_i,
    output logic [MP*32-1:0]             tcdm_add_o,
    output logic [MP-1:0]                tcdm_wen_o,
    output logic [MP*MemDataWidth/8-1:0] tcdm_be_o,
    output logic [MP*MemDataWidth-1:0]   tcdm_data_o,
    input  logic [MP*MemDataWidth-1:0]   tcdm_r_data_i,
    input  logic [MP-1:0]                tcdm_r_valid_i,
    output logic [31:0]                  stall_cnt_o
);

    localparam int BeW = MemDataWidth / 8;

    logic [MP-1:0]           granted_q;
    logic [MP-1:0]           expect_q;
    logic [MP-1:0]           got_q;
    logic [MemDataWidth-1:0] rd_buf_q [MP];
    logic                    rd_pending_q;
    logic [31:0]             stall_cnt_q;

    logic [MP-1:0] skip;
    logic [MP-1:0] lane_req;
    logic [MP-1:0] lane_gnt;
    logic [MP-1:0] lane_ok;
    logic [MP-1:0] resp_hit;
    logic [MP-1:0] resp_ok;
    logic          wide_gnt;
    logic          wide_r_valid;

`ifdef ITA_TCDM_LANE_SKIP_EN
    always_comb begin
        for (int i = 0; i < MP; i++) begin
            skip[i] = ~wide_wen_i & ~(|wide_be_i[i*BeW +: BeW]);
        end
    end
`else
    assign skip = '0;
`endif

    // Combinational handshakes are gated by reset so nothing leaks out while rst_i is high.
    assign lane_req     = {MP{wide_req_i & ~rst_i}} & ~granted_q & ~skip;
    assign lane_gnt     = lane_req & tcdm_gnt_i;
    assign lane_ok      = granted_q | skip | lane_gnt;
    assign wide_gnt     = wide_req_i & ~rst_i & (&lane_ok);
    assign resp_hit     = tcdm_r_valid_i & expect_q;
    assign resp_ok      = got_q | resp_hit;
    assign wide_r_valid = ~rst_i & rd_pending_q & (&resp_ok);

    assign wide_gnt_o     = wide_gnt;
    assign wide_r_valid_o = wide_r_valid;
    assign tcdm_req_o     = lane_req;
    assign tcdm_wen_o     = {MP{wide_wen_i}};
    assign tcdm_be_o      = wide_be_i;
    assign tcdm_data_o    = wide_data_i;
    assign stall_cnt_o    = stall_cnt_q;

    always_comb begin
        for (int i = 0; i < MP; i++) begin
            tcdm_add_o[i*32 +: 32] = wide_add_i + 32'(i * BeW);
        end
    end

    // A lane responding this cycle bypasses its buffer so the wide response can complete immediately.
    always_comb begin
        for (int i = 0; i < MP; i++) begin
            if (rst_i) begin
                wide_r_data_o[i*MemDataWidth +: MemDataWidth] = '0;
            end else if (resp_hit[i]) begin
                wide_r_data_o[i*MemDataWidth +: MemDataWidth] = tcdm_r_data_i[i*MemDataWidth +: MemDataWidth];
            end else begin
                wide_r_data_o[i*MemDataWidth +: MemDataWidth] = rd_buf_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            granted_q    <= '0;
            expect_q     <= '0;
            got_q        <= '0;
            rd_pending_q <= 1'b0;
            stall_cnt_q  <= '0;
            for (int i = 0; i < MP; i++) begin
                rd_buf_q[i] <= '0;
            end
        end else begin
            granted_q <= wide_gnt ? '0 : (granted_q | lane_gnt);
            // A new read grant on a lane wins over the previous read's response clearing it.
            expect_q  <= (expect_q & ~resp_hit) | (lane_gnt & {MP{wide_wen_i}});
            got_q     <= wide_r_valid ? '0 : (got_q | resp_hit);
            for (int i = 0; i < MP; i++) begin
                if (resp_hit[i]) begin
                    rd_buf_q[i] <= tcdm_r_data_i[i*MemDataWidth +: MemDataWidth];
                end
            end
            if (wide_gnt & wide_wen_i) begin
                rd_pending_q <= 1'b1;
            end else if (wide_r_valid) begin
                rd_pending_q <= 1'b0;
            end
            if (wide_req_i & ~wide_gnt & ~(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ita_tcdm_lane_sequencer.sv
// Testbench for ita_tcdm_lane_sequencer: directed and random wide transactions against a lane memory model.
module tb_ita_tcdm_lane_sequencer;

    localparam int AW = 1024;
    localparam int MW = 64;
    localparam int MP = 16;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            wide_req_i;
    logic            wide_gnt_o;
    logic [31:0]     wide_add_i;
    logic            wide_wen_i;
    logic [AW/8-1:0] wide_be_i;
    logic [AW-1:0]   wide_data_i;
    logic            wide_r_valid_o;
    logic [AW-1:0]   wide_r_data_o;
    logic [MP-1:0]   tcdm_req_o;
    logic [MP-1:0]   tcdm_gnt_i;
    logic [MP*32-1:0] tcdm_add_o;
    logic [MP-1:0]   tcdm_wen_o;
    logic [MP*8-1:0] tcdm_be_o;
    logic [MP*MW-1:0] tcdm_data_o;
    logic [MP*MW-1:0] tcdm_r_data_i;
    logic [MP-1:0]   tcdm_r_valid_i;
    logic [31:0]     stall_cnt_o;

    always #5 clk_i = ~clk_i;

    ita_tcdm_lane_sequencer #(.AccDataWidth(AW), .MemDataWidth(MW), .MP(MP)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wide_req_i(wide_req_i), .wide_gnt_o(wide_gnt_o), .wide_add_i(wide_add_i),
        .wide_wen_i(wide_wen_i), .wide_be_i(wide_be_i), .wide_data_i(wide_data_i),
        .wide_r_valid_o(wide_r_valid_o), .wide_r_data_o(wide_r_data_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .stall_cnt_o(stall_cnt_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: word-addressed memory behind the lanes, pending lane responses, expected wide read.
    logic [63:0]   mem [256];
    logic [31:0]   model_stall;
    logic          rv_due;
    logic [63:0]   exp_rd [MP];
    logic [MP-1:0] pend_v;
    logic [63:0]   pend_d [MP];
    logic [MP-1:0] stray;
    int            gsched [MP];

    function automatic logic [7:0] idx(input logic [31:0] a);
        return a[10:3];
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive lane responses, check outputs before the edge, advance the model.
    task automatic tick(input logic [MP-1:0] exp_req, input logic exp_wgnt, input logic chk_zero);
        logic [MP-1:0] fire;
        logic          rv_next;
        logic [63:0]   rd_next [MP];
        logic [31:0]   la;
        tcdm_r_valid_i = pend_v | stray;
        for (int i = 0; i < MP; i++) tcdm_r_data_i[i*MW +: MW] = pend_d[i];
        #7;
        if (rst_i) begin
            exp_req  = '0;
            exp_wgnt = 1'b0;
        end
        checkOutput("tcdm_req", tcdm_req_o, exp_req);
        checkOutput("wide_gnt", wide_gnt_o, exp_wgnt);
        checkOutput("wide_r_valid", wide_r_valid_o, rv_due && !rst_i);
        checkOutput("stall_cnt", stall_cnt_o, model_stall);
        if (rv_due && !rst_i)
            for (int i = 0; i < MP; i++)
                checkOutput($sformatf("r_data[%0d]", i), wide_r_data_o[i*MW +: MW], exp_rd[i]);
        if (chk_zero)
            for (int i = 0; i < MP; i++)
                checkOutput($sformatf("r_data_zero[%0d]", i), wide_r_data_o[i*MW +: MW], 0);
        if (wide_req_i && !rst_i) begin
            checkOutput("tcdm_wen", tcdm_wen_o, {MP{wide_wen_i}});
            checkOutput("tcdm_be", tcdm_be_o, wide_be_i);
            for (int i = 0; i < MP; i++) begin
                checkOutput($sformatf("tcdm_add[%0d]", i), tcdm_add_o[i*32 +: 32], wide_add_i + 32'(8 * i));
                checkOutput($sformatf("tcdm_data[%0d]", i), tcdm_data_o[i*MW +: MW], wide_data_i[i*MW +: MW]);
            end
        end
        fire    = tcdm_req_o & tcdm_gnt_i;
        rv_next = 1'b0;
        for (int i = 0; i < MP; i++) rd_next[i] = '0;
        if (rst_i) begin
            model_stall = '0;
        end else begin
            if (wide_req_i && !exp_wgnt && model_stall != 32'hFFFF_FFFF) model_stall = model_stall + 1;
            if (exp_wgnt && wide_wen_i) begin
                rv_next = 1'b1;
                for (int i = 0; i < MP; i++) rd_next[i] = mem[idx(wide_add_i + 32'(8 * i))];
            end
        end
        for (int i = 0; i < MP; i++) begin
            if (fire[i]) begin
                la = wide_add_i + 32'(8 * i);
                if (wide_wen_i) begin
                    pend_d[i] = mem[idx(la)];
                end else begin
                    for (int b = 0; b < 8; b++)
                        if (wide_be_i[i*8 + b]) mem[idx(la)][b*8 +: 8] = wide_data_i[i*MW + b*8 +: 8];
                    pend_d[i] = {$urandom(), $urandom()};
                end
            end
        end
        @(posedge clk_i);
        #1;
        rv_due = rv_next;
        if (rv_next) for (int i = 0; i < MP; i++) exp_rd[i] = rd_next[i];
        pend_v = fire;
    endtask

    // Hold one wide request until its last lane is granted; lane i is granted from cycle gsched[i].
    task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [127:0] be,
                                 input logic [AW-1:0] data);
        logic [MP-1:0] skip;
        logic [MP-1:0] er;
        int last;
        skip = '0;
`ifdef ITA_TCDM_LANE_SKIP_EN
        for (int i = 0; i < MP; i++) skip[i] = !wen && (be[i*8 +: 8] == 8'h00);
`endif
        last = 0;
        for (int i = 0; i < MP; i++) if (!skip[i] && gsched[i] > last) last = gsched[i];
        wide_req_i  = 1'b1;
        wide_wen_i  = wen;
        wide_add_i  = addr;
        wide_be_i   = be;
        wide_data_i = data;
        for (int c = 0; c <= last; c++) begin
            for (int i = 0; i < MP; i++) begin
                tcdm_gnt_i[i] = (c >= gsched[i]);
                er[i]         = !skip[i] && (c <= gsched[i]);
            end
            tick(er, c == last, 1'b0);
        end
    endtask

    task automatic idle();
        wide_req_i = 1'b0;
        tcdm_gnt_i = '0;
        tick('0, 1'b0, 1'b0);
    endtask

    function automatic logic [AW-1:0] rand_data();
        logic [AW-1:0] d;
        for (int k = 0; k < AW / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = {$urandom(), $urandom()};
        for (int i = 0; i < MP; i++) begin
            pend_d[i] = '0;
            exp_rd[i] = '0;
            gsched[i] = 0;
        end
        rst_i = 1'b1; wide_req_i = 1'b0; wide_add_i = '0; wide_wen_i = 1'b0;
        wide_be_i = '0; wide_data_i = '0; tcdm_gnt_i = '0; tcdm_r_valid_i = '0; tcdm_r_data_i = '0;
        pend_v = '0; stray = '0; rv_due = 1'b0; model_stall = '0;
        @(posedge clk_i);
        #1;
        $display("[TB] reset state");
        tick('0, 1'b0, 1'b1);
        rst_i = 1'b0;
        tick('0, 1'b0, 1'b1);

        $display("[TB] read 0x1000, all lanes granted at once");
        applyStimulus(1'b1, 32'h1000, '1, '0);
        idle();

        $display("[TB] staggered read, lane i granted in cycle i");
        for (int i = 0; i < MP; i++) gsched[i] = i;
        applyStimulus(1'b1, 32'h1100, '1, '0);
        idle();
        checkOutput("stall_after_stagger", stall_cnt_o, 32'd15);

        $display("[TB] back-to-back reads");
        for (int i = 0; i < MP; i++) gsched[i] = 0;
        applyStimulus(1'b1, 32'h1200, '1, '0);
        applyStimulus(1'b1, 32'h1280, '1, '0);
        idle();

        $display("[TB] partial-be write, then read back");
        applyStimulus(1'b0, 32'h1000, 128'hFFFF, rand_data());
        idle();
        applyStimulus(1'b0, 32'h1400, '0, rand_data());
        idle();
        applyStimulus(1'b1, 32'h1000, '1, '0);
        idle();

        $display("[TB] reset after 8 of 16 lanes granted");
        wide_req_i = 1'b1; wide_wen_i = 1'b1; wide_add_i = 32'h1300; wide_be_i = '1;
        tcdm_gnt_i = 16'h00FF;
        tick('1, 1'b0, 1'b0);
        rst_i = 1'b1;
        tcdm_gnt_i = '0;
        tick('0, 1'b0, 1'b0);
        rst_i = 1'b0;
        wide_req_i = 1'b0;
        stray = '1;
        tick('0, 1'b0, 1'b1);
        stray = '0;
        applyStimulus(1'b1, 32'h1300, '1, '0);
        idle();

        $display("[TB] random transactions");
        for (int t = 0; t < 24; t++) begin
            logic          w;
            logic [31:0]   a;
            logic [127:0]  b;
            w = 1'($urandom_range(0, 1));
            a = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd8;
            b = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int i = 0; i < MP; i++) begin
                if ($urandom_range(0, 2) == 0) b[i*8 +: 8] = 8'h00;
                gsched[i] = $urandom_range(0, 3);
            end
            applyStimulus(w, a, b, rand_data());
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        idle();

        $display("[TB] stall counter saturation");
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        model_stall = 32'hFFFF_FFFE;
        for (int i = 0; i < MP; i++) gsched[i] = 3;
        applyStimulus(1'b1, 32'h1500, '1, '0);
        idle();
        checkOutput("stall_saturated", stall_cnt_o, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ita_tcdm_lane_sequencer.md
# ita_tcdm_lane_sequencer

Sequences one wide ITA HWPE TCDM transaction (AccDataWidth bits) onto MP narrow memory lanes of MemDataWidth bits each. Each lane is granted independently, so a lane is never re-requested after its grant. Narrow read responses are collected into one wide response. The block sits between the HCI `tcdm` master of `ita_hwpe_top` and the cluster TCDM ports, in the HWPE wrapper.

## Interface
- AccDataWidth, 1024, wide data width in bits
- MemDataWidth, 64, lane data width in bits
- MP, AccDataWidth/MemDataWidth, lane count; must be an integer ≥ 1
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- wide_req_i  in  1  wide request; held stable with add/wen/be/data until wide_gnt_o
- wide_gnt_o  out  1  wide request accepted (all lanes granted)
- wide_add_i  in  32  byte address of lane 0
- wide_wen_i  in  1  1 = read, 0 = write
- wide_be_i  in  AccDataWidth/8  byte enables
- wide_data_i  in  AccDataWidth  write data
- wide_r_valid_o  out  1  wide read response valid, one cycle per read
- wide_r_data_o  out  AccDataWidth  wide read data; lane i occupies bits [i*MemDataWidth +: MemDataWidth]
- tcdm_req_o  out  MP  per-lane request
- tcdm_gnt_i  in  MP  per-lane grant
- tcdm_add_o  out  MP×32  lane address = wide_add_i + i*(MemDataWidth/8)
- tcdm_wen_o  out  MP  = wide_wen_i
- tcdm_be_o  out  MP×MemDataWidth/8  be slice of lane i
- tcdm_data_o  out  MP×MemDataWidth  data slice of lane i
- tcdm_r_data_i  in  MP×MemDataWidth  lane read data
- tcdm_r_valid_i  in  MP  lane response valid, exactly 1 cycle after that lane's grant
- stall_cnt_o  out  32  cycles with wide_req_i=1 and wide_gnt_o=0; saturates at 2^32-1

## Operation
- Registers:
  - granted[MP]: lanes granted for the current wide request.
  - expect[MP]: read lanes awaiting a response.
  - got[MP] with buf[MP]: captured read data.
  - rd_pending: a read has been wide-granted and its response is not yet delivered.
- Lane request: tcdm_req_o[i] = wide_req_i & ~granted[i] & ~skip[i]. skip = 0 unless the Configuration feature is enabled.
- Lane done: lane_ok[i] = granted[i] | skip[i] | (tcdm_req_o[i] & tcdm_gnt_i[i]).
- wide_gnt_o = wide_req_i & (&lane_ok). The signal is combinational, in the cycle the last lane is granted.
- On each lane grant:
  - Set granted[i].
  - If the request is a read, set expect[i].
- On wide_gnt_o:
  - Clear granted to all-zero.
  - If the request is a read, set rd_pending.
- On tcdm_r_valid_i[i] & expect[i]:
  - Store the data in buf[i].
  - Set got[i] and clear expect[i].
- tcdm_r_valid_i[i] with expect[i]=0 (e.g. a write response, or a response arriving after reset) is ignored.
- wide_r_valid_o = rd_pending & &(got | (tcdm_r_valid_i & expect)). It is combinational in the cycle the last lane response arrives.
- wide_r_data_o: for each lane, the live lane data if that lane's response arrives this cycle, else buf.
- On wide_r_valid_o:
  - Clear got and rd_pending.
  - If a new read is wide-granted in the same cycle, rd_pending stays 1.
- Writes never produce wide_r_valid_o.
- At most one read is pending. With the fixed 1-cycle lane latency, the next wide grant cannot precede completion of the previous read.

## Timing
- All MP lanes granted in cycle T: wide_gnt_o in T; wide_r_valid_o (reads) in T+1.
- Lanes granted across T0..Tn: wide_gnt_o in Tn; wide_r_valid_o in Tn+1. Early lane data is held in buf.
- Back-to-back requests: a new wide request may issue lane requests in the cycle after wide_gnt_o.
- Reset values:
  - wide_gnt_o=0, wide_r_valid_o=0, tcdm_req_o=0 (while rst_i=1).
  - wide_r_data_o=0, stall_cnt_o=0.
  - All masks, buf and rd_pending cleared.
- Reset mid-transaction:
  - Partial grants are forgotten, and the request restarts from scratch after reset.
  - Responses arriving after reset are dropped.
- stall_cnt_o increments in every cycle where wide_req_i & ~wide_gnt_o, and holds at saturation.

## Configuration
- ITA_TCDM_LANE_SKIP_EN defined:
  - For writes (wide_wen_i=0), skip[i] = ~|tcdm_be_o[i].
  - Lanes with all-zero byte enables are never requested and count as granted.
  - If all be are zero, wide_gnt_o asserts in the same cycle as wide_req_i.
- ITA_TCDM_LANE_SKIP_EN undefined: skip = 0, and every lane is always requested.
- Reads always request all lanes, with or without the macro.

## Test plan
- MP=16, read at 0x1000, all tcdm_gnt_i=1:
  - wide_gnt_o in cycle 0.
  - wide_r_valid_o in cycle 1, with lane i data at bits [64i+:64].
  - tcdm_add_o[5]=0x1028.
- Staggered grants, lane i granted in cycle i:
  - Each lane requested exactly until its grant.
  - wide_gnt_o in cycle 15; wide_r_valid_o in cycle 16 with data from all lanes.
  - stall_cnt_o=15.
- Back-to-back reads A then B, all grants immediate:
  - A's wide_r_valid_o coincides with B's wide_gnt_o.
  - B's response follows one cycle later; no data mixing.
- Write with be=0 on lanes 2..15, lanes 0..1 granted:
  - With ITA_TCDM_LANE_SKIP_EN: only lanes 0..1 requested; wide_gnt_o in cycle 0.
  - Without the macro: all lanes requested.
  - In both cases wide_r_valid_o is never asserted.
- rst_i asserted after 8 of 16 lanes are granted:
  - Outputs are 0 next cycle.
  - Stray lane r_valids are ignored.
  - A request re-issued after reset re-requests all 16 lanes.
- Saturation: preload stall_cnt_o to 0xFFFFFFFE (force) and hold the stall 3 cycles; stall_cnt_o stays at 0xFFFFFFFF.
